// File: rtl/clk_domain_sequencer.sv
// Sequences the divided 2f (/4) and f (/8) clock domains off clk8f: warm-up, run, and a drain
// that always stops on a whole f period.
module clk_domain_sequencer #(
  parameter int unsigned WARMUP = 16
) (
  input  logic       clk8f,
  input  logic       reset_L,
  input  logic       run_req,
  input  logic       stop_req,
  output logic       ready,
  output logic       running,
  output logic [2:0] phase,
  output logic       ce2f,
  output logic       cef,
  output logic       clk2f_lvl,
  output logic       clkf_lvl,
  output logic [7:0] frame_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2,
    StDrain  = 2'd3
  } state_e;

  // The counter is loaded with WARMUP-1 so that reaching zero marks the last warm-up cycle.
  localparam logic [7:0] WarmupLoad = 8'(WARMUP - 1);

  state_e     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] frame_q, frame_d;

  logic       active;
  logic       last_phase;

  assign active     = (state_q == StRun) || (state_q == StDrain);
  assign last_phase = (phase_q == 3'd7);

  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      phase_q <= 3'd0;
      wcnt_q  <= 8'd0;
      frame_q <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wcnt_q  <= wcnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    frame_d = frame_q;

    unique case (state_q)
      StIdle: begin
        phase_d = 3'd0;
        // A simultaneous stop request vetoes the start.
        if (run_req && !stop_req) begin
          state_d = StWarmup;
          wcnt_d  = WarmupLoad;
          frame_d = 8'd0;
        end
      end

      StWarmup: begin
        phase_d = 3'd0;
        if (stop_req) begin
          state_d = StIdle;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == 8'd0) begin
          state_d = StRun;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end

      StRun, StDrain: begin
        phase_d = phase_q + 3'd1;
        if (last_phase) begin
          frame_d = frame_q + 8'd1;
        end
        if (state_q == StRun) begin
          if (stop_req) begin
            state_d = last_phase ? StIdle : StDrain;
          end
        end else if (last_phase) begin
          state_d = StIdle;
        end
        // Leaving the active states always lands on phase 0, even if the wrap logic changes.
        if (state_d == StIdle) begin
          phase_d = 3'd0;
        end
      end

      default: begin
        state_d = StIdle;
        phase_d = 3'd0;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    ready     = (state_q == StIdle);
    running   = active;
    phase     = phase_q;
    ce2f      = active && (phase_q[1:0] == 2'b11);
    cef       = active && last_phase;
    clk2f_lvl = active ? ~phase_q[1] : 1'b1;
    clkf_lvl  = active ? ~phase_q[2] : 1'b1;
    frame_cnt = frame_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_clk_domain_sequencer.sv
// Scoreboard bench for clk_domain_sequencer: stimulus queues per-cycle expected output vectors,
// a monitor pops and compares them on the falling clk8f edge.
module tb_clk_domain_sequencer;

  logic       clk8f    = 1'b0;
  logic       reset_L  = 1'b0;
  logic       run_req  = 1'b0;
  logic       stop_req = 1'b0;
  logic       ready;
  logic       running;
  logic [2:0] phase;
  logic       ce2f;
  logic       cef;
  logic       clk2f_lvl;
  logic       clkf_lvl;
  logic [7:0] frame_cnt;
  logic [1:0] state;

  clk_domain_sequencer #(.WARMUP(16)) dut (
    .clk8f    (clk8f),
    .reset_L  (reset_L),
    .run_req  (run_req),
    .stop_req (stop_req),
    .ready    (ready),
    .running  (running),
    .phase    (phase),
    .ce2f     (ce2f),
    .cef      (cef),
    .clk2f_lvl(clk2f_lvl),
    .clkf_lvl (clkf_lvl),
    .frame_cnt(frame_cnt),
    .state    (state)
  );

  always #5 clk8f = ~clk8f;

  int cyc = 0;
  always @(posedge clk8f) cyc <= cyc + 1;

  // Vector layout: {ready, running, phase, ce2f, cef, clk2f_lvl, clkf_lvl, frame_cnt, state}
  typedef struct {
    int          cyc;
    string       nm;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event async_ev;

  // Per-phase decode tables, bit i = value at phase i.
  logic [7:0] ce2f_tbl = 8'b1000_1000;
  logic [7:0] cef_tbl  = 8'b1000_0000;
  logic [7:0] l2_tbl   = 8'b0011_0011;
  logic [7:0] lf_tbl   = 8'b0000_1111;

  int n_cef  = 0;
  int n_ce2f = 0;
  always @(negedge clk8f) begin
    if (cef) n_cef++;
    if (ce2f) n_ce2f++;
  end

  task automatic push(input int c, input string nm, input logic [18:0] v);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic exp_idle(input int c, input string nm, input logic [7:0] fc);
    push(c, nm, {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, fc, 2'd0});
  endtask

  task automatic exp_warm(input int c, input string nm, input logic [7:0] fc);
    push(c, nm, {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, fc, 2'd1});
  endtask

  task automatic exp_act(input int c, input string nm, input logic [2:0] ph,
                         input logic [7:0] fc, input logic [1:0] st);
    push(c, nm, {1'b0, 1'b1, ph, ce2f_tbl[ph], cef_tbl[ph], l2_tbl[ph], lf_tbl[ph], fc, st});
  endtask

  task automatic exp_run_span(input int c0, input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      exp_act(c0 + k, nm, 3'(k % 8), 8'(k / 8), 2'd2);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk8f);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: compares every queued vector whose cycle has arrived.
  always begin
    exp_t        e;
    logic [18:0] a;
    @(negedge clk8f or async_ev);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = {ready, running, phase, ce2f, cef, clk2f_lvl, clkf_lvl, frame_cnt, state};
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s missed cycle %0d (now %0d)", e.nm, e.cyc, cyc);
      end else if (a !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", e.nm, cyc, a, e.v);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t5;
    int c0;
    int e0;

    for (int k = 1; k <= 5; k++) exp_idle(k, "reset", 8'd0);
    goto(2);
    reset_L = 1'b1;
    goto(5);

    // Start, three frames, stop at phase 2 -> five drain cycles.
    t = cyc + 2;
    exp_idle(t, "s1_idle", 8'd0);
    for (int k = 1; k <= 16; k++) exp_warm(t + k, "s1_warm", 8'd0);
    exp_run_span(t + 17, 27, "s1_run");
    for (int k = 0; k < 5; k++) exp_act(t + 44 + k, "s1_drain", 3'(3 + k), 8'd3, 2'd3);
    exp_idle(t + 49, "s1_end", 8'd4);
    exp_idle(t + 50, "s1_end_hold", 8'd4);
    c0 = n_cef;
    e0 = n_ce2f;
    goto(t);      run_req  = 1'b1;
    goto(t + 1);  run_req  = 1'b0;
    goto(t + 43); stop_req = 1'b1;
    goto(t + 44); stop_req = 1'b0;
    goto(t + 51);
    chk("s1_cef_count", n_cef - c0, 4);
    chk("s1_ce2f_count", n_ce2f - e0, 8);

    // Stop at phase 7 goes straight to idle; run_req toggles in RUN; run+stop in IDLE stays idle.
    t = cyc + 2;
    exp_idle(t, "s2_idle", 8'd4);
    for (int k = 1; k <= 16; k++) exp_warm(t + k, "s2_warm", 8'd0);
    exp_run_span(t + 17, 16, "s2_run");
    for (int k = 33; k <= 37; k++) exp_idle(t + k, "s2_idle_end", 8'd2);
    goto(t);     run_req = 1'b1;
    goto(t + 1); run_req = 1'b0;
    for (int c = t + 17; c <= t + 31; c++) begin
      goto(c);
      run_req = c[0];
    end
    goto(t + 32); run_req = 1'b1; stop_req = 1'b1;
    goto(t + 36); run_req = 1'b0; stop_req = 1'b0;
    goto(t + 38);

    // Stop during warm-up with the counter at 5: no strobes at all.
    t = cyc + 2;
    exp_idle(t, "s3_idle", 8'd2);
    for (int k = 1; k <= 11; k++) exp_warm(t + k, "s3_warm", 8'd0);
    for (int k = 12; k <= 20; k++) exp_idle(t + k, "s3_idle_end", 8'd0);
    c0 = n_cef;
    e0 = n_ce2f;
    goto(t);      run_req  = 1'b1;
    goto(t + 1);  run_req  = 1'b0;
    goto(t + 11); stop_req = 1'b1;
    goto(t + 12); stop_req = 1'b0;
    goto(t + 21);
    chk("s3_cef_count", n_cef - c0, 0);
    chk("s3_ce2f_count", n_ce2f - e0, 0);

    // 260 frames with run_req toggling throughout; frame_cnt wraps to 4.
    t = cyc + 2;
    exp_idle(t, "s4_idle", 8'd0);
    for (int k = 1; k <= 16; k++) exp_warm(t + k, "s4_warm", 8'd0);
    exp_run_span(t + 17, 2077, "s4_run");
    for (int k = 0; k < 3; k++) exp_act(t + 2094 + k, "s4_drain", 3'(5 + k), 8'd3, 2'd3);
    exp_idle(t + 2097, "s4_wrap", 8'd4);
    c0 = n_cef;
    e0 = n_ce2f;
    goto(t);     run_req = 1'b1;
    goto(t + 1); run_req = 1'b0;
    for (int c = t + 17; c <= t + 2096; c++) begin
      goto(c);
      run_req  = c[0];
      stop_req = (c == t + 2093);
    end
    goto(t + 2097); run_req = 1'b0; stop_req = 1'b0;
    goto(t + 2099);
    chk("s4_cef_count", n_cef - c0, 260);
    chk("s4_ce2f_count", n_ce2f - e0, 520);

    // Asynchronous reset mid-drain at phase 5, then a restart with first-run timing.
    t = cyc + 2;
    exp_idle(t, "s5_idle", 8'd4);
    for (int k = 1; k <= 16; k++) exp_warm(t + k, "s5_warm", 8'd0);
    exp_run_span(t + 17, 2, "s5_run");
    for (int k = 0; k < 4; k++) exp_act(t + 19 + k, "s5_drain", 3'(2 + k), 8'd0, 2'd3);
    goto(t);      run_req  = 1'b1;
    goto(t + 1);  run_req  = 1'b0;
    goto(t + 18); stop_req = 1'b1;
    goto(t + 19); stop_req = 1'b0;
    goto(t + 22);
    #1 reset_L = 1'b0;
    #1;
    exp_idle(t + 22, "s5_async_reset", 8'd0);
    ->async_ev;
    for (int k = 23; k <= 25; k++) exp_idle(t + k, "s5_in_reset", 8'd0);
    t5 = t + 26;
    exp_idle(t5, "s5_re_idle", 8'd0);
    for (int k = 1; k <= 16; k++) exp_warm(t5 + k, "s5_re_warm", 8'd0);
    exp_run_span(t5 + 17, 16, "s5_re_run");
    exp_idle(t5 + 33, "s5_re_end", 8'd2);
    goto(t + 24);  reset_L  = 1'b1;
    goto(t5);      run_req  = 1'b1;
    goto(t5 + 1);  run_req  = 1'b0;
    goto(t5 + 32); stop_req = 1'b1;
    goto(t5 + 33); stop_req = 1'b0;
    goto(t5 + 36);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_domain_sequencer.md
# clk_domain_sequencer

Controller that sequences the divided clock domains derived from the master clock `clk8f`. After a run request and a programmable warm-up, it runs a 3-bit phase counter that produces single-cycle clock-enable strobes and level signals for the 2f (÷4) and f (÷8) domains. On a stop request it drains to a clean f-frame boundary before going idle. It sits beside the clock generator and gates the start and stop of every downstream 2f/f consumer (muxes, striping, serializers).

## Interface
- `WARMUP`, 16: clk8f cycles spent in WARMUP before RUN; legal range 1..255.
- `clk8f` in 1: master clock; every flop is on its rising edge.
- `reset_L` in 1: asynchronous, active-low reset; deassertion must be synchronous to `clk8f`.
- `run_req` in 1: level; sampled in IDLE to start the sequence.
- `stop_req` in 1: level; sampled in WARMUP/RUN to stop.
- `ready` out 1: 1 when state is IDLE.
- `running` out 1: 1 in RUN or DRAIN.
- `phase` out 3: clk8f phase within the current f period; 0 when not running.
- `ce2f` out 1: 1 in cycles with `running` and `phase` 3 or 7.
- `cef` out 1: 1 in cycles with `running` and `phase` 7.
- `clk2f_lvl` out 1: `~phase[1]` while running, else 1.
- `clkf_lvl` out 1: `~phase[2]` while running, else 1.
- `frame_cnt` out 8: number of `cef` pulses since the last start; wraps 255→0.
- `state` out 2: IDLE=0, WARMUP=1, RUN=2, DRAIN=3 (debug).

## Operation
- All outputs are Moore decodes of the state, `phase`, `frame_cnt` and warm-up counter registers. No input-to-output combinational path.
- Reset values: state IDLE, `phase`=0, warm-up counter 0, `frame_cnt`=0, `ready`=1, `running`=0, `ce2f`=`cef`=0, `clk2f_lvl`=`clkf_lvl`=1.
- IDLE:
  - `run_req`=1 and `stop_req`=0 → WARMUP, with the counter loaded to WARMUP-1 and `frame_cnt` cleared.
  - `run_req` and `stop_req` both 1 → stay IDLE (stop wins).
- WARMUP:
  - `phase` is held at 0 and the counter decrements each cycle.
  - `stop_req`=1 → IDLE and the counter is cleared.
  - Otherwise, counter==0 → RUN.
- RUN:
  - `phase` increments mod 8 every cycle, starting at 0 on RUN entry.
  - `frame_cnt` increments (8-bit wrap) on every cycle where `phase`==7.
  - `stop_req`=1 with `phase`==7 → IDLE; that cycle's `cef` is the last one.
  - `stop_req`=1 with `phase`≠7 → DRAIN.
  - `run_req` is ignored.
- DRAIN:
  - `phase`, strobes and `frame_cnt` behave as in RUN.
  - `phase`==7 → IDLE, with `phase` forced to 0.
  - `run_req` and `stop_req` are ignored.
- Guarantee: every RUN episode emits only whole f periods. Strobe counts per episode: `cef` = N, `ce2f` = 2N.
- `reset_L` low in any state returns immediately to reset values and aborts any drain. No partial frame is reported.

## Timing
- `run_req` sampled high in IDLE at edge T:
  - `ready` falls after T.
  - WARMUP occupies cycles T+1 .. T+WARMUP.
  - RUN begins at cycle T+WARMUP+1 with `phase`=0.
  - First `ce2f` occurs in cycle T+WARMUP+4; first `cef` in cycle T+WARMUP+8.
- `ce2f` is high in the last clk8f cycle before each rising edge of `clk2f_lvl`. `cef` likewise precedes each rising edge of `clkf_lvl`.
- `clk2f_lvl` is high for `phase` 0-1 and low for 2-3, period 4. `clkf_lvl` is high for `phase` 0-3 and low for 4-7, period 8.
- `stop_req` sampled in RUN at `phase`=p (p≠7): DRAIN lasts 7-p cycles, then IDLE. `ready`=1 in the cycle after the final `cef`.
- Stop-to-idle latency is at most 8 cycles. Start-to-first-`cef` latency is exactly WARMUP+8 cycles.
- WARMUP=1 gives a single WARMUP cycle.

## Test plan
- Reset, then `run_req` pulse at cycle 0 with WARMUP=16 → `running` rises at cycle 17; `ce2f` in cycles 20, 24, 28…; `cef` in cycles 24, 32…; `clk2f_lvl`/`clkf_lvl` match the phase decode.
- Stop at `phase`=2 in RUN after 3 frames → DRAIN for 5 cycles; IDLE after the 4th `cef`; `frame_cnt`=4; `phase`=0; both levels =1.
- Stop at `phase`=7 → direct RUN→IDLE in the next cycle; no DRAIN state observed; `frame_cnt` counts that cycle's frame.
- `run_req` and `stop_req` both high in IDLE → stays IDLE. `stop_req` in WARMUP at counter 5 → IDLE with no strobes emitted.
- Run 260 frames → `frame_cnt` wraps to 4. `run_req` toggling in RUN and DRAIN has no effect.
- Assert `reset_L` low asynchronously mid-DRAIN at `phase`=5 → all outputs take reset values before the next `clk8f` edge. A restart after reset follows the first scenario's timing exactly.
